mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/klp_mmio_pkg.sv | 31 +++
 rtl/mmio_fifo.sv | 45 ++++
 rtl/mmio_uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/klp_mmio_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets,
// STATUS/CTRL bit positions and the transmit state encoding.
package klp_mmio_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_LEVEL_LSB = 8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // A divisor of zero would stall the bit timer, so it is stored as one.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous first-word-fall-through FIFO; pop_data shows the head entry
// whenever the FIFO is non-empty.
module mmio_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: storage has no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, a programmable bit
// divisor, stall-safe write decoding and an idle interrupt.
module mmio_uart_tx
  import klp_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wr_data,
  output logic [31:0] bus_rd_data,
  input  logic        bus_cs,
  input  logic        bus_wr,
  input  logic        bus_rd,
  output logic        uart_tx,
  output logic        irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic        sel;
  logic [1:0]  idx;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        wr_stb;

  logic        ctrl_en;
  logic        ctrl_irq_en;
  logic [15:0] divisor;
  logic        overflow;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic [LW-1:0] fifo_level;

  tx_state_t   state;
  logic [15:0] cnt;
  logic [15:0] div_q;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  logic        txdata_wr;
  logic        frame_end;
  logic        bypass;
  logic        ovf_set;
  logic        load;
  logic [7:0]  load_byte;
  logic [31:0] status;

  assign sel = bus_cs & (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign idx = bus_addr[3:2];

  // A store held over several cycles by a pipeline stall matches the
  // previous cycle's access exactly and is therefore performed only once.
  assign wr_stb = sel & bus_wr & ~(wr_q & (addr_q == bus_addr) & (data_q == bus_wr_data));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q   <= sel & bus_wr;
      addr_q <= bus_addr;
      data_q <= bus_wr_data;
    end
  end

  // An empty FIFO with an idle, enabled transmitter hands the written byte
  // straight to the shifter so the start bit appears one cycle later.
  assign txdata_wr = wr_stb & (idx == REG_TXDATA);
  assign frame_end = (state == TX_STOP) & (cnt == 16'd0);
  assign fifo_pop  = ctrl_en & ~fifo_empty & ((state == TX_IDLE) | frame_end);
  assign bypass    = ctrl_en & fifo_empty & (state == TX_IDLE) & txdata_wr;
  assign fifo_push = txdata_wr & ~bypass & (~fifo_full | fifo_pop);
  assign ovf_set   = txdata_wr & fifo_full & ~fifo_pop;
  assign load      = fifo_pop | bypass;
  assign load_byte = bypass ? bus_wr_data[7:0] : fifo_data;

  mmio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus_wr_data[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      divisor     <= DEFAULT_DIV;
      overflow    <= 1'b0;
    end else begin
      if (wr_stb && idx == REG_CTRL) begin
        ctrl_en     <= bus_wr_data[CTRL_EN];
        ctrl_irq_en <= bus_wr_data[CTRL_IRQ_EN];
      end
      if (wr_stb && idx == REG_DIVISOR) divisor <= clamp_div(bus_wr_data[15:0]);
      if (ovf_set) overflow <= 1'b1;
      else if (wr_stb && idx == REG_STATUS && bus_wr_data[ST_OVF]) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      div_q   <= DEFAULT_DIV;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
      irq     <= 1'b0;
    end else begin
      irq <= ctrl_irq_en & fifo_empty & (state == TX_IDLE);
      if (load) begin
        state   <= TX_START;
        div_q   <= divisor;
        cnt     <= divisor - 16'd1;
        bit_idx <= '0;
        shreg   <= load_byte;
        uart_tx <= 1'b0;
      end else begin
        case (state)
          TX_IDLE: uart_tx <= 1'b1;
          TX_START: begin
            if (cnt == 16'd0) begin
              state   <= TX_DATA;
              cnt     <= div_q - 16'd1;
              uart_tx <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          TX_DATA: begin
            if (cnt == 16'd0) begin
              cnt <= div_q - 16'd1;
              if (bit_idx == 3'd7) begin
                state   <= TX_STOP;
                uart_tx <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                uart_tx <= shreg[0];
                shreg   <= {1'b0, shreg[7:1]};
              end
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          TX_STOP: begin
            if (cnt == 16'd0) state <= TX_IDLE;
            else              cnt   <= cnt - 16'd1;
          end
        endcase
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    status                       = '0;
    status[ST_FULL]              = fifo_full;
    status[ST_EMPTY]             = fifo_empty;
    status[ST_BUSY]              = (state != TX_IDLE);
    status[ST_OVF]               = overflow;
    status[ST_LEVEL_LSB +: 4]    = 4'(fifo_level);
  end

  always_comb begin
    bus_rd_data = '0;
    if (sel && bus_rd) begin
      case (idx)
        REG_TXDATA:  bus_rd_data = '0;
        REG_STATUS:  bus_rd_data = status;
        REG_CTRL:    bus_rd_data = {30'd0, ctrl_irq_en, ctrl_en};
        REG_DIVISOR: bus_rd_data = {16'd0, divisor};
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vector table, directed
// multi-cycle sequences and randomized frames against a waveform model.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX   = 32'h1000_0000;
  localparam logic [31:0] A_ST   = 32'h1000_0004;
  localparam logic [31:0] A_CTRL = 32'h1000_0008;
  localparam logic [31:0] A_DIV  = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wr_data = '0;
  logic [31:0] bus_rd_data;
  logic        bus_cs = 1'b0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic        uart_tx;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  mmio_uart_tx #(
    .BASE_ADDR   (32'h1000_0000),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_cs      (bus_cs),
    .bus_wr      (bus_wr),
    .bus_rd      (bus_rd),
    .uart_tx     (uart_tx),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wr_data = d;
    @(negedge clk);
    bus_cs = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = a;
    #1;
    d = bus_rd_data;
    bus_cs = 1'b0; bus_rd = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_queue();
    foreach (exp_q[i]) bus_write(A_TX, {24'd0, exp_q[i]});
  endtask

  // Counts cycles until the line drops, bounded so a silent DUT still ends.
  task automatic wait_start(input string name, input int exp_lat);
    int n;
    n = 0;
    while (uart_tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, n, exp_lat);
  endtask

  // Expected line level at cycle k of back-to-back 8N1 frames of exp_q.
  task automatic check_frames(input string name, input int div, input int k0, input bit end_idle);
    int total;
    int bad;
    int pos;
    logic exp_bit;
    logic [7:0] cur;
    total = exp_q.size() * 10 * div;
    bad = 0;
    for (int k = k0; k < total; k++) begin
      cur = exp_q[k / (10 * div)];
      pos = (k % (10 * div)) / div;
      if (pos == 0)      exp_bit = 1'b0;
      else if (pos == 9) exp_bit = 1'b1;
      else               exp_bit = cur[3'(pos - 1)];
      if (uart_tx !== exp_bit) bad++;
      @(negedge clk);
    end
    check({name, " bit errors"}, bad, 0);
    if (end_idle) check({name, " idle after"}, {31'd0, uart_tx}, 1);
  endtask

  task automatic count_low(input string name, input int cycles);
    int lows;
    lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check(name, lows, 0);
  endtask

  initial begin
    logic [31:0] rd;
    int n, div;
    bit ie;

    vecs[0]  = '{1'b0, 32'h0,          32'h0,          A_ST,           32'h0000_0002};
    vecs[1]  = '{1'b0, 32'h0,          32'h0,          A_CTRL,         32'h0};
    vecs[2]  = '{1'b0, 32'h0,          32'h0,          A_DIV,          32'h0000_0364};
    vecs[3]  = '{1'b1, A_CTRL,         32'hFFFF_FFFE,  A_CTRL,         32'h0000_0002};
    vecs[4]  = '{1'b1, 32'h2000_0008,  32'h3,          A_CTRL,         32'h0000_0002};
    vecs[5]  = '{1'b1, 32'h1000_000B,  32'h0,          A_CTRL,         32'h0};
    vecs[6]  = '{1'b1, A_DIV,          32'hABCD_1234,  A_DIV,          32'h0000_1234};
    vecs[7]  = '{1'b1, A_DIV,          32'h0,          A_DIV,          32'h0000_0001};
    vecs[8]  = '{1'b1, A_DIV,          32'h0005_0000,  A_DIV,          32'h0000_0001};
    vecs[9]  = '{1'b1, A_DIV,          32'h0000_FFFF,  A_DIV,          32'h0000_FFFF};
    vecs[10] = '{1'b0, 32'h0,          32'h0,          32'h1000_0010,  32'h0};
    vecs[11] = '{1'b0, 32'h0,          32'h0,          A_TX,           32'h0};
    vecs[12] = '{1'b1, A_ST,           32'hFFFF_FFFF,  A_ST,           32'h0000_0002};

    repeat (3) @(negedge clk);
    check("reset uart_tx", {31'd0, uart_tx}, 1);
    check("reset irq", {31'd0, irq}, 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].wa, vecs[i].wd);
      bus_read(vecs[i].ra, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    bus_cs = 1'b1; bus_addr = A_DIV;
    #1 check("rd gated by bus_rd", bus_rd_data, 0);
    bus_cs = 1'b0;

    bus_write(A_CTRL, 32'h2);
    @(negedge clk);
    check("irq idle empty", {31'd0, irq}, 1);
    bus_write(A_CTRL, 32'h0);
    @(negedge clk);
    check("irq disabled", {31'd0, irq}, 0);

    // Single byte into an empty FIFO with the transmitter enabled.
    bus_write(A_DIV, 32'd4);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_TX, 32'h55);
    wait_start("tx 0x55 latency", 0);
    exp_q = '{8'h55};
    check_frames("frame 0x55", 4, 0, 1);
    bus_write(A_CTRL, 32'h0);

    // Store held for three cycles by a stall.
    bus_write(A_DIV, 32'd2);
    @(negedge clk);
    bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = A_TX; bus_wr_data = 32'h41;
    repeat (3) @(negedge clk);
    bus_cs = 1'b0; bus_wr = 1'b0;
    check_reg("stall level", A_ST, 32'h0000_0100);
    bus_write(A_CTRL, 32'h1);
    wait_start("stall latency", 1);
    exp_q = '{8'h41};
    check_frames("stall frame", 2, 0, 1);
    count_low("stall single frame", 40);
    check_reg("stall drained", A_ST, 32'h0000_0002);
    bus_write(A_CTRL, 32'h0);

    // Back-to-back stores with different data are both taken.
    @(negedge clk);
    bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = A_TX; bus_wr_data = 32'h61;
    @(negedge clk);
    bus_wr_data = 32'h62;
    @(negedge clk);
    bus_cs = 1'b0; bus_wr = 1'b0;
    check_reg("b2b level", A_ST, 32'h0000_0200);
    apply_reset();

    // Overflow: nine pushes into eight entries.
    for (int i = 0; i < 9; i++) bus_write(A_TX, 32'h10 + i);
    check_reg("ovf status", A_ST, 32'h0000_0809);
    bus_write(A_ST, 32'h0);
    check_reg("ovf sticky", A_ST, 32'h0000_0809);
    bus_write(A_ST, 32'h8);
    check_reg("ovf cleared", A_ST, 32'h0000_0801);
    bus_write(A_DIV, 32'd1);
    bus_write(A_CTRL, 32'h1);
    wait_start("ovf latency", 1);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
    check_frames("ovf drain", 1, 0, 1);
    check_reg("ovf drained", A_ST, 32'h0000_0002);
    bus_write(A_CTRL, 32'h0);

    // Three queued frames, contiguous, then irq.
    apply_reset();
    bus_write(A_DIV, 32'd3);
    exp_q = '{8'hA1, 8'hB2, 8'hC3};
    push_queue();
    bus_write(A_CTRL, 32'h3);
    wait_start("3 frame latency", 1);
    check_frames("3 frames", 3, 0, 1);
    check("irq at stop end", {31'd0, irq}, 0);
    @(negedge clk);
    check("irq after stop", {31'd0, irq}, 1);
    bus_write(A_CTRL, 32'h0);

    // Divisor written mid-frame applies to the following frame.
    bus_write(A_DIV, 32'd2);
    exp_q = '{8'h3C, 8'hC5};
    push_queue();
    bus_write(A_CTRL, 32'h1);
    wait_start("div change latency", 1);
    bus_write(A_DIV, 32'd3);
    exp_q = '{8'h3C};
    check_frames("div old frame", 2, 2, 0);
    exp_q = '{8'hC5};
    check_frames("div new frame", 3, 0, 1);

    // Enable cleared mid-frame: the frame completes, the next byte waits.
    bus_write(A_CTRL, 32'h0);
    exp_q = '{8'h96, 8'h69};
    push_queue();
    bus_write(A_CTRL, 32'h1);
    wait_start("disable latency", 1);
    bus_write(A_CTRL, 32'h0);
    exp_q = '{8'h96};
    check_frames("disable frame", 3, 2, 1);
    count_low("disable stays idle", 60);
    check_reg("disable level", A_ST, 32'h0000_0100);
    apply_reset();

    // Randomized frames against the waveform model.
    for (int it = 0; it < 6; it++) begin
      n   = $urandom_range(1, 4);
      div = $urandom_range(1, 5);
      ie  = 1'($urandom_range(0, 1));
      exp_q.delete();
      for (int j = 0; j < n; j++) exp_q.push_back(8'($urandom));
      bus_write(A_DIV, div);
      push_queue();
      check_reg($sformatf("rand%0d level", it), A_ST, 32'(n) << 8);
      bus_write(A_CTRL, {30'd0, ie, 1'b1});
      wait_start($sformatf("rand%0d latency", it), 1);
      check_frames($sformatf("rand%0d frames", it), div, 0, 1);
      check($sformatf("rand%0d irq at end", it), {31'd0, irq}, 0);
      @(negedge clk);
      check($sformatf("rand%0d irq after", it), {31'd0, irq}, {31'd0, ie});
      bus_write(A_CTRL, 32'h0);
    end

    // Reset in the middle of the data bits.
    bus_write(A_DIV, 32'd4);
    bus_write(A_TX, 32'hA5);
    bus_write(A_CTRL, 32'h1);
    wait_start("reset test latency", 1);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset mid frame line", {31'd0, uart_tx}, 1);
    check_reg("reset mid frame status", A_ST, 32'h0000_0002);
    @(negedge clk);
    reset = 1'b0;
    check_reg("reset ctrl", A_CTRL, 32'h0);
    check_reg("reset divisor", A_DIV, 32'h0000_0364);
    count_low("reset no partial byte", 60);
    check("reset irq low", {31'd0, irq}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
